// File: rtl/aes_pkg.sv
// Shared AES constants for the byte-serial AES-128 datapath.
// Provides the key-schedule round constants, the key-stream FSM state
// encoding, block sizes, and a helper that returns Rcon for a round number.
package aes_pkg;

  localparam int AES_KEY_BYTES = 16;
  localparam int AES_ROUNDS    = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    EMIT = ST_EMIT,
    DONE = ST_DONE
  } ks_state_e;

  // Rcon[1..10] stored at index 0..9
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for round 1..10; zero outside that range
  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    logic [3:0] k;
    k = round - 4'd1;
    if (round >= 4'd1 && round <= 4'(AES_ROUNDS)) return RCON[k];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox_comb.sv
// Purely combinational AES forward S-box (256-entry lookup).
// Ports:
//   din  - input byte
//   dout - S(din)
module aes_sbox_comb (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_stream.sv
// Byte-serial AES-128 key schedule. Loads the 16-byte cipher key one byte
// per cycle, then streams the 11 round keys (176 bytes) one byte per cycle,
// computing each byte on the fly from the previous round key.
// Ports:
//   clock, reset             - clock, synchronous active-high reset
//   key_in/key_in_valid/key_in_ready - cipher-key byte input handshake
//   key_out/key_valid/key_ready      - round-key byte output handshake
//   round_idx                - round (0..10) of key_out
//   key_last                 - key_out is byte 15 of its round key
//   done                     - one-cycle pulse after the final byte is taken
module aes_key_stream
  import aes_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] key_in,
  input  logic       key_in_valid,
  output logic       key_in_ready,
  output logic [7:0] key_out,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] round_idx,
  output logic       key_last,
  output logic       done
);

  ks_state_e  state, state_nxt;
  logic [3:0] byte_idx;
  logic [7:0] prev_rk [AES_KEY_BYTES];

  logic       load_fire, emit_fire, last_byte, final_byte;
  logic [3:0] nxt_idx, nxt_round;
  logic [7:0] sb_in, sb_out, t_byte, rk_byte_p0, shift_byte;

  assign last_byte  = (byte_idx == 4'(AES_KEY_BYTES - 1));
  assign final_byte = last_byte && (round_idx == 4'(AES_ROUNDS));
  assign load_fire  = key_in_valid && key_in_ready;
  assign emit_fire  = key_valid && key_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    key_in_ready = 1'b0;
    key_valid    = 1'b0;
    key_last     = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        key_in_ready = !reset;
        if (key_in_valid && !reset) state_nxt = LOAD;
      end
      LOAD: begin
        key_in_ready = !reset;
        if (key_in_valid && !reset && last_byte) state_nxt = EMIT;
      end
      EMIT: begin
        key_valid = 1'b1;
        key_last  = last_byte;
        if (key_ready && final_byte) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: next round-key byte from the shift register.
  // The shift register has advanced once per byte produced in the current
  // round, so P[i] always sits at [0], N[i-4] at [12], and the rotated
  // SubWord source P[12+((i+1) mod 4)] at [13] for i=0..2 and [9] for i=3.
  assign nxt_idx   = byte_idx + 4'd1;
  assign nxt_round = last_byte ? round_idx + 4'd1 : round_idx;
  assign sb_in     = (nxt_idx < 4'd3) ? prev_rk[13] : prev_rk[9];

  aes_sbox_comb u_sbox (
    .din  (sb_in),
    .dout (sb_out)
  );

  always_comb begin
    t_byte = prev_rk[12];
    if (nxt_idx < 4'd4) begin
      t_byte = sb_out;
      if (nxt_idx == 4'd0) t_byte = sb_out ^ rcon_of(nxt_round);
    end
    rk_byte_p0 = (nxt_round == 4'd0) ? prev_rk[0] : (prev_rk[0] ^ t_byte);
    shift_byte = (state == EMIT) ? rk_byte_p0 : key_in;
  end

  // Stage p1: registered output byte and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx  <= '0;
      round_idx <= '0;
      key_out   <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (load_fire) begin
            byte_idx <= nxt_idx;
            if (last_byte) key_out <= prev_rk[1];
          end
        end
        EMIT: begin
          if (key_ready) begin
            if (final_byte) begin
              byte_idx  <= '0;
              round_idx <= '0;
            end else begin
              byte_idx  <= nxt_idx;
              round_idx <= nxt_round;
              key_out   <= rk_byte_p0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // On the last load byte the register is rotated by one extra position so
  // it already reflects round-0 byte 0 having been emitted.
  always_ff @(posedge clock) begin
    if (load_fire && last_byte) begin
      for (int k = 0; k < 14; k++) prev_rk[k] <= prev_rk[k+2];
      prev_rk[14] <= key_in;
      prev_rk[15] <= prev_rk[1];
    end else if (load_fire || (emit_fire && !final_byte)) begin
      for (int k = 0; k < 15; k++) prev_rk[k] <= prev_rk[k+1];
      prev_rk[15] <= shift_byte;
    end
  end

endmodule

// File: tb/tb_aes_key_stream.sv
module tb_aes_key_stream;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] key_in = 8'h00;
  logic       key_in_valid = 1'b0;
  logic       key_in_ready;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic [3:0] round_idx;
  logic       key_last;
  logic       done;

  aes_key_stream dut (
    .clock        (clock),
    .reset        (reset),
    .key_in       (key_in),
    .key_in_valid (key_in_valid),
    .key_in_ready (key_in_ready),
    .key_out      (key_out),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .round_idx    (round_idx),
    .key_last     (key_last),
    .done         (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] r;
    logic       l;
    logic [7:0] b;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           nvec = 0;
  int           nerr = 0;
  logic [7:0]   cap [176];
  logic [7:0]   mdl [176];
  logic [127:0] ref_run [11];
  int           xfer_cnt = 0;
  int           done_cnt = 0;
  int           cyc = 0;
  bit           seen_valid = 0;
  bit           chk_timing = 0;
  bit           prev_stall = 0;
  logic [7:0]   prev_out;
  logic [3:0]   prev_round;
  logic         prev_last;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // ---------------- reference model (FIPS-197 word-oriented expansion) ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 176; i++) mdl[i] = w[i/4][31-8*(i%4) -: 8];
  endtask

  function automatic logic [127:0] cap_round(input int r);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = cap[16*r+i];
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (seen_valid) cyc++;
    else if (key_valid) begin
      seen_valid = 1;
      cyc = 1;
    end
    if (key_valid) begin
      chk("in_ready_in_emit", key_in_ready, 1'b0);
      if (prev_stall) begin
        chk("stall_key_out", key_out, prev_out);
        chk("stall_round", round_idx, prev_round);
        chk("stall_last", key_last, prev_last);
      end
      if (key_ready) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_byte: got %0h expected none", key_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("key_out", key_out, mon_e.b);
          chk("round_idx", round_idx, mon_e.r);
          chk("key_last", key_last, mon_e.l);
          if (xfer_cnt < 176) cap[xfer_cnt] = key_out;
          xfer_cnt++;
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (chk_timing) chk("done_latency", cyc, 177);
    end
    prev_stall = key_valid && !key_ready;
    prev_out   = key_out;
    prev_round = round_idx;
    prev_last  = key_last;
  end

  // ---------------- driver ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_out"}, key_out, 8'h00);
    chk({tag, "_key_valid"}, key_valid, 1'b0);
    chk({tag, "_key_in_ready"}, key_in_ready, 1'b0);
    chk({tag, "_round_idx"}, round_idx, 4'd0);
    chk({tag, "_key_last"}, key_last, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic prep(input logic [127:0] key, input bit timing);
    exp_q.delete();
    seen_valid = 0; cyc = 0; done_cnt = 0; xfer_cnt = 0;
    chk_timing = timing;
    expand(key);
    for (int i = 0; i < 176; i++)
      exp_q.push_back('{r: 4'(i / 16), l: (i % 16 == 15), b: mdl[i]});
  endtask

  task automatic load_key(input logic [127:0] key, input bit gapped);
    int i, n;
    bit v;
    i = 0; n = 0;
    while (i < 16) begin
      chk("no_valid_during_load", key_valid, 1'b0);
      chk("in_ready_during_load", key_in_ready, 1'b1);
      v = gapped ? ((n % 5 == 0) || (n % 5 == 2)) : 1'b1;
      key_in_valid = v;
      key_in = v ? key[127-8*i -: 8] : 8'($urandom);
      @(posedge clock); #1;
      n++;
      if (v) i++;
    end
    key_in_valid = 1'b0;
    chk("first_valid", key_valid, 1'b1);
    chk("first_byte", key_out, key[127:120]);
  endtask

  task automatic run_stream(input bit stalls, input bit junk, input int abort_at);
    int n;
    bit stalled;
    n = 0; stalled = 0;
    while (done !== 1'b1 && n < 4000) begin
      if (abort_at >= 0 && key_valid && xfer_cnt == abort_at) break;
      if (!stalls) key_ready = 1'b1;
      else if (key_last && !stalled) begin
        key_ready = 1'b0;
        stalled = 1;
      end else begin
        key_ready = 1'($urandom_range(0, 1));
        if (!key_last) stalled = 0;
      end
      if (junk) begin
        key_in_valid = 1'b1;
        key_in = 8'($urandom);
      end
      @(posedge clock); #1;
      n++;
    end
    key_in_valid = 1'b0;
    if (n >= 4000) begin
      nvec++; nerr++;
      $display("FAIL stream_timeout: got %0d cycles expected done", n);
    end
    if (abort_at < 0) begin
      key_ready = 1'b0;
      @(posedge clock); #1;
      chk("done_single_cycle", done, 1'b0);
      chk("done_count", done_cnt, 1);
      chk("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    logic [127:0] k;

    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    chk("ready_after_reset", key_in_ready, 1'b1);
    @(posedge clock); #1;

    // FIPS-197 known-answer, no stalls
    prep(FIPS_KEY, 1);
    load_key(FIPS_KEY, 0);
    run_stream(0, 0, -1);
    chk("fips_round0", cap_round(0), FIPS_KEY);
    chk("fips_round1", cap_round(1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_round10", cap_round(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int r = 0; r < 11; r++) ref_run[r] = cap_round(r);

    // all-zero key
    prep(128'h0, 1);
    load_key(128'h0, 0);
    run_stream(0, 0, -1);
    chk("zero_round1", cap_round(1), {4{32'h62636363}});

    // FIPS key again with random stalls including every key_last byte
    prep(FIPS_KEY, 0);
    load_key(FIPS_KEY, 0);
    run_stream(1, 0, -1);
    for (int r = 0; r < 11; r++) chk("stall_vs_nostall", cap_round(r), ref_run[r]);

    // gapped loading, random key
    k = {$urandom, $urandom, $urandom, $urandom};
    prep(k, 1);
    load_key(k, 1);
    run_stream(0, 0, -1);

    // reset while round 5 byte 7 is presented
    k = {$urandom, $urandom, $urandom, $urandom};
    prep(k, 0);
    load_key(k, 0);
    run_stream(0, 0, 87);
    chk("abort_point_round", round_idx, 4'd5);
    chk("abort_point_xfers", xfer_cnt, 87);
    reset = 1'b1;
    key_ready = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("abort");
    reset = 1'b0;
    key_ready = 1'b0;
    @(posedge clock); #1;
    k = {$urandom, $urandom, $urandom, $urandom};
    prep(k, 1);
    load_key(k, 0);
    run_stream(0, 0, -1);

    // key_in_valid with random data throughout EMIT
    k = {$urandom, $urandom, $urandom, $urandom};
    prep(k, 1);
    load_key(k, 0);
    run_stream(0, 1, -1);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
